// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin arbiter sharing one UART TX FIFO write port among NUM_REQ requesters,
//          with the grant held for a whole message. Optional forced release: UART_ARB_TIMEOUT_EN.
// Latency: grant one cycle after req in IDLE; bytes pass combinationally from the granted requester.
// Backpressure: tx_full stalls wr_uart and ack together, so no byte is lost or written twice.
module uart_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DBIT    = 8,
   parameter int TIMEOUT = 1023
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ*DBIT-1:0] data,
   input  logic [NUM_REQ-1:0]      last,
   output logic [NUM_REQ-1:0]      ack,
   output logic [NUM_REQ-1:0]      grant,
   output logic                    busy,
   input  logic                    tx_full,
   output logic                    wr_uart,
   output logic [DBIT-1:0]         w_data,
   output logic                    timeout
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {IDLE, LOCK} state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;

   logic [PTR_W-1:0]     g_idx;
   logic                 req_g;
   logic                 last_g;
   logic [DBIT-1:0]      sel_data;
   logic                 found;
   logic [PTR_W-1:0]     sel_idx;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 timeout_q, timeout_d;
`endif

   // Datapath: route the granted requester's byte and handshake to the FIFO port.
   always_comb begin
      g_idx    = '0;
      req_g    = 1'b0;
      last_g   = 1'b0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) begin
            g_idx    = PTR_W'(i);
            req_g    = req[i];
            last_g   = last[i];
            sel_data = data[i*DBIT +: DBIT];
         end
      end
      wr_uart = req_g & ~tx_full;
      w_data  = wr_uart ? sel_data : '0;
      ack     = grant_q & {NUM_REQ{wr_uart}};
   end

   // Round-robin pick: first pending requester above the last one served.
   always_comb begin
      found   = 1'b0;
      sel_idx = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         int idx;
         idx = (int'(ptr_q) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found   = 1'b1;
            sel_idx = PTR_W'(idx);
         end
      end
   end

   // Next-state: grant on any request in IDLE, release on the last byte (or on timeout).
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_d     = '0;
      timeout_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d          = LOCK;
               grant_d          = '0;
               grant_d[sel_idx] = 1'b1;
            end
         end
         LOCK: begin
            if (wr_uart && last_g) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = g_idx;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (!wr_uart) begin
               if (cnt_q == CNT_W'(TIMEOUT)) begin
                  state_d   = IDLE;
                  grant_d   = '0;
                  ptr_d     = g_idx;
                  timeout_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
`endif
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State register; pointer resets to the top index so requester 0 wins first.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= PTR_W'(NUM_REQ - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   // Idle-cycle counter inside a locked grant and the one-cycle release pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign grant = grant_q;
   assign busy  = (state_q == LOCK);

endmodule
